// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG data-register chains behind the TAP controller:
// control bundle, default chain width and the bit-counter width helper.
package jtag_pkg;

    localparam int DEFAULT_CHAIN_WIDTH = 16;

    // Per-chain TAP state decode, already qualified by chain selection.
    typedef struct packed {
        logic capture;
        logic shift;
        logic update;
    } chain_ctrl_t;

    // The counter must represent 0..n plus one extra "too many bits" value.
    function automatic int count_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/jtag_shift_counter.sv
// Saturating shift-length counter for a JTAG data-register chain; flags when
// exactly WIDTH bits have been shifted since the last clear.
module jtag_shift_counter
    import jtag_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CHAIN_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic exact
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] CNT_EXACT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT   = CW'(WIDTH + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && count != CNT_SAT) begin
            count <= count + CW'(1);
        end
    end

    assign exact = (count == CNT_EXACT);

endmodule

// File: rtl/drive_chain.sv
// JTAG drive chain: serially loaded on Shift-DR, committed to DataOut on
// Update-DR only when exactly DATAWIDTH bits were shifted.
module drive_chain
    import jtag_pkg::*;
#(
    parameter int                  DATAWIDTH  = DEFAULT_CHAIN_WIDTH,
    parameter logic [DATAWIDTH-1:0] RESETVALUE = '0
) (
    input  logic                 TCK,
    input  logic                 Reset,
    input  logic                 ScanIn,
    input  logic                 CaptureDR,
    input  logic                 ShiftDR,
    input  logic                 UpdateDR,
    output logic                 ScanOut,
    output logic [DATAWIDTH-1:0] DataOut,
    output logic                 UpdateStrobe,
    output logic                 LengthError
);

    chain_ctrl_t            ctrl;
    logic [DATAWIDTH-1:0]   shift_reg;
    logic                   len_exact;
    logic                   cnt_clear;
    logic                   cnt_incr;

    assign ctrl.capture = CaptureDR;
    assign ctrl.shift   = ShiftDR;
    assign ctrl.update  = UpdateDR;

    // Capture outranks shift, shift outranks update; any surviving capture or
    // update restarts the length count.
    assign cnt_clear = ctrl.capture | (~ctrl.shift & ctrl.update);
    assign cnt_incr  = ~ctrl.capture & ctrl.shift;

    jtag_shift_counter #(
        .WIDTH(DATAWIDTH)
    ) u_shift_counter (
        .clk  (TCK),
        .rst  (Reset),
        .clear(cnt_clear),
        .incr (cnt_incr),
        .exact(len_exact)
    );

    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            shift_reg    <= '0;
            DataOut      <= RESETVALUE;
            UpdateStrobe <= 1'b0;
            LengthError  <= 1'b0;
        end else begin
            UpdateStrobe <= 1'b0;
            if (ctrl.capture) begin
                shift_reg <= DataOut;
            end else if (ctrl.shift) begin
                shift_reg <= {ScanIn, shift_reg[DATAWIDTH-1:1]};
            end else if (ctrl.update) begin
                if (len_exact) begin
                    DataOut      <= shift_reg;
                    UpdateStrobe <= 1'b1;
                    LengthError  <= 1'b0;
                end else begin
                    LengthError  <= 1'b1;
                end
            end
        end
    end

    assign ScanOut = shift_reg[0];

endmodule

// File: tb/tb_drive_chain.sv
// Randomized self-checking bench for drive_chain against a queue-based model
// of the chain's scan/commit rules.
module tb_drive_chain;

    localparam int          W     = 16;
    localparam logic [15:0] RSTV  = 16'hA5A5;

    logic          TCK;
    logic          Reset;
    logic          ScanIn;
    logic          CaptureDR;
    logic          ShiftDR;
    logic          UpdateDR;
    logic          ScanOut;
    logic [W-1:0]  DataOut;
    logic          UpdateStrobe;
    logic          LengthError;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: scan path as a bit queue (front = ScanOut), shift length
    // as a plain integer clamped at W+1.
    bit            m_q[$];
    int            m_len;
    logic [W-1:0]  m_data;
    logic          m_strobe;
    logic          m_lerr;

    drive_chain #(
        .DATAWIDTH (W),
        .RESETVALUE(RSTV)
    ) dut (
        .TCK         (TCK),
        .Reset       (Reset),
        .ScanIn      (ScanIn),
        .CaptureDR   (CaptureDR),
        .ShiftDR     (ShiftDR),
        .UpdateDR    (UpdateDR),
        .ScanOut     (ScanOut),
        .DataOut     (DataOut),
        .UpdateStrobe(UpdateStrobe),
        .LengthError (LengthError)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < W; i++) m_q.push_back(1'b0);
        m_len    = 0;
        m_data   = RSTV;
        m_strobe = 1'b0;
        m_lerr   = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit s, input bit u, input bit si);
        logic [W-1:0] word;
        m_strobe = 1'b0;
        if (c) begin
            m_q.delete();
            for (int i = 0; i < W; i++) m_q.push_back(m_data[i]);
            m_len = 0;
        end else if (s) begin
            m_q.push_back(si);
            void'(m_q.pop_front());
            m_len = (m_len + 1 > W + 1) ? W + 1 : m_len + 1;
        end else if (u) begin
            if (m_len == W) begin
                for (int i = 0; i < W; i++) word[i] = m_q[i];
                m_data   = word;
                m_strobe = 1'b1;
                m_lerr   = 1'b0;
            end else begin
                m_lerr = 1'b1;
            end
            m_len = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".scan_out"}, ScanOut, m_q[0]);
        check({tag, ".data_out"}, DataOut, m_data);
        check({tag, ".strobe"},   UpdateStrobe, m_strobe);
        check({tag, ".len_err"},  LengthError, m_lerr);
    endtask

    // Drives one TCK worth of controls, advances the model on the edge and
    // compares just after it.
    task automatic step(input string tag, input bit c, input bit s, input bit u, input bit si);
        CaptureDR = c;
        ShiftDR   = s;
        UpdateDR  = u;
        ScanIn    = si;
        @(posedge TCK);
        model_step(c, s, u, si);
        #1;
        CaptureDR = 1'b0;
        ShiftDR   = 1'b0;
        UpdateDR  = 1'b0;
        ScanIn    = 1'b0;
        check_outputs(tag);
    endtask

    task automatic scan(input string tag, input logic [31:0] value, input int nbits);
        for (int i = 0; i < nbits; i++) step(tag, 1'b0, 1'b1, 1'b0, value[i % 32]);
    endtask

    initial begin
        logic [15:0] readback;
        logic [31:0] rval;
        int          op;
        int          len;

        Reset = 1'b1; ScanIn = 1'b0; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
        model_reset();
        #1;
        check("reset.data_out", DataOut, 32'h0000_A5A5);
        check_outputs("reset");
        #11;
        Reset = 1'b0;

        // Readback of the reset value, LSB first.
        step("cap0", 1'b1, 1'b0, 1'b0, 1'b0);
        readback = '0;
        readback[0] = ScanOut;
        for (int i = 1; i < W; i++) begin
            step("rb", 1'b0, 1'b1, 1'b0, 1'b0);
            readback[i] = ScanOut;
        end
        check("readback.word", readback, 32'h0000_A5A5);
        step("rb_last", 1'b0, 1'b1, 1'b0, 1'b0);
        check("readback.hold", DataOut, 32'h0000_A5A5);

        // Valid 16-bit update.
        step("cap1", 1'b1, 1'b0, 1'b0, 1'b0);
        scan("s1234", 32'h1234, W);
        step("upd1234", 1'b0, 1'b0, 1'b1, 1'b0);
        check("upd1234.value", DataOut, 32'h0000_1234);
        check("upd1234.pulse", UpdateStrobe, 1'b1);
        step("post1234", 1'b0, 1'b0, 1'b0, 1'b0);
        check("post1234.pulse_gone", UpdateStrobe, 1'b0);

        // Short scan rejected, then a good scan clears the flag.
        step("cap2", 1'b1, 1'b0, 1'b0, 1'b0);
        scan("short", 32'hFFFF, W - 1);
        step("upd_short", 1'b0, 1'b0, 1'b1, 1'b0);
        check("short.value", DataOut, 32'h0000_1234);
        check("short.len_err", LengthError, 1'b1);
        step("cap3", 1'b1, 1'b0, 1'b0, 1'b0);
        scan("s0001", 32'h0001, W);
        step("upd0001", 1'b0, 1'b0, 1'b1, 1'b0);
        check("s0001.value", DataOut, 32'h0000_0001);
        check("s0001.len_err", LengthError, 1'b0);

        // Long scan saturates the count and is rejected.
        step("cap4", 1'b1, 1'b0, 1'b0, 1'b0);
        scan("long", 32'h000A_BCDE, 20);
        step("upd_long", 1'b0, 1'b0, 1'b1, 1'b0);
        check("long.value", DataOut, 32'h0000_0001);
        check("long.len_err", LengthError, 1'b1);

        // Asynchronous reset mid-shift, checked between clock edges.
        step("cap5", 1'b1, 1'b0, 1'b0, 1'b0);
        scan("pre_rst", 32'h5A5A, 7);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check("async.data_out", DataOut, 32'h0000_A5A5);
        check("async.scan_out", ScanOut, 1'b0);
        check("async.len_err",  LengthError, 1'b0);
        #2;
        Reset = 1'b0;
        step("upd_noshift", 1'b0, 1'b0, 1'b1, 1'b0);
        check("noshift.len_err", LengthError, 1'b1);

        // Capture and update together: capture wins, then count restarts.
        step("cap6", 1'b1, 1'b0, 1'b0, 1'b0);
        scan("sBEEF", 32'hBEEF, W);
        step("cap_upd", 1'b1, 1'b0, 1'b1, 1'b0);
        check("cap_upd.no_pulse", UpdateStrobe, 1'b0);
        check("cap_upd.value",    DataOut, 32'h0000_A5A5);
        step("upd_after_cap", 1'b0, 1'b0, 1'b1, 1'b0);
        check("after_cap.len_err", LengthError, 1'b1);

        // Randomized sequences of legal and illegal TAP activity.
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: step("r_cap", 1'b1, 1'b0, 1'b0, 1'b0);
                1: begin
                    rval = $urandom;
                    len  = int'($urandom_range(W - 2, W + 2));
                    if ($urandom_range(0, 1) == 1) step("r_cap", 1'b1, 1'b0, 1'b0, 1'b0);
                    scan("r_scan", rval, ($urandom_range(0, 2) == 0) ? len : W);
                end
                2: step("r_upd", 1'b0, 1'b0, 1'b1, 1'b0);
                3: step("r_idle", 1'b0, 1'b0, 1'b0, 1'b0);
                default: step("r_mix", 1'(($urandom) & 1), 1'(($urandom) & 1),
                              1'(($urandom) & 1), 1'(($urandom) & 1));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
